// File: rtl/temp_conv_pkg.sv
// Shared types, constants and the temperature conversion used by the table builder.
package temp_conv_pkg;

  localparam int unsigned TABLE_DEPTH = 256;
  localparam int unsigned F_OFFSET    = 32;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 8;

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_e;
  typedef enum logic {C2F = 1'b0, F2C = 1'b1} mode_e;

  // Same function feeds the FILL write data and the VERIFY expected value.
  function automatic logic [DATA_W-1:0] conv(input mode_e m, input logic [ADDR_W-1:0] a);
    logic [11:0]       t12;
    logic [10:0]       t11;
    logic [DATA_W-1:0] r;
    t12 = '0;
    t11 = '0;
    r   = '0;
    if (m == C2F) begin
      t12 = ({4'd0, a} * 12'd9) / 12'd5 + 12'(F_OFFSET);
      r   = (t12 > 12'd255) ? '1 : 8'(t12);
    end else if (a >= 8'(F_OFFSET)) begin
      t11 = ({3'd0, 8'(a - 8'(F_OFFSET))} * 11'd5) / 11'd9;
      r   = 8'(t11);
    end
    return r;
  endfunction

endpackage

// File: rtl/temp_table_builder_ram.sv
// 256x8 single-port synchronous RAM, read-first, registered output, no reset.
module table_ram
  import temp_conv_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [TABLE_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/temp_table_builder.sv
// Builds a 256-entry C->F or F->C lookup table in RAM, reads it back to verify,
// then serves external reads of the completed table.
module temp_table_builder
  import temp_conv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_addr
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              valid_q, valid_d;
  logic              rd_ok_q, rd_ok_d;
  logic [7:0]        err_addr_q, err_addr_d;
  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr, chk_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (accept) state_d = FILL;
      FILL:       if (cnt_q == 9'(TABLE_DEPTH - 1)) state_d = VERIFY;
      VERIFY:     if (cnt_q == 9'(TABLE_DEPTH)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == FILL) || (state_q == VERIFY);
    ram_we    = (state_q == FILL);
    ram_addr  = busy ? cnt_q[7:0] : rd_addr;
    ram_wdata = conv(mode_q, cnt_q[7:0]);
  end

  // VERIFY cycle n checks the word read in cycle n-1, hence the extra 257th cycle.
  always_comb begin
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    valid_d    = valid_q;
    chk_addr   = cnt_q[7:0] - 8'd1;
    if (accept) begin
      cnt_d      = '0;
      mode_d     = mode_e'(mode);
      error_d    = 1'b0;
      err_addr_d = '0;
      valid_d    = 1'b0;
    end else if (state_q == FILL) begin
      cnt_d = (state_d == VERIFY) ? '0 : cnt_q + 9'd1;
    end else if (state_q == VERIFY) begin
      cnt_d = cnt_q + 9'd1;
      if (cnt_q != '0 && ram_rdata != conv(mode_q, chk_addr)) begin
        error_d = 1'b1;
        if (!error_q) err_addr_d = chk_addr;
      end
      if (state_d == DONE) valid_d = 1'b1;
    end
    done_d  = (state_q == DONE) && !accept;
    rd_ok_d = valid_q && !busy && !accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= C2F;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      valid_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      valid_q    <= valid_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  table_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign rd_data  = rd_ok_q ? ram_rdata : '0;
  assign done     = done_q;
  assign error    = error_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_temp_table_builder.sv
// Self-checking bench for temp_table_builder: vector table, random reads vs. model, corner sequences.
module tb_temp_table_builder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] rd_addr = 8'd0;
  logic [7:0] rd_data;
  logic       busy, done, error;
  logic [7:0] err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  temp_table_builder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic int model(input int m, input int a);
    int r;
    if (m == 0) begin
      r = (a * 9) / 5 + 32;
      if (r > 255) r = 255;
    end else begin
      r = (a < 32) ? 0 : ((a - 32) * 5) / 9;
    end
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic rd(input int a, output int d);
    @(negedge clk);
    rd_addr = 8'(a);
    @(posedge clk);
    #1;
    d = int'(rd_data);
  endtask

  // action: 0 none, 1 start pulse at FILL cycle 100, 2 corrupt 77 and 200, 3 corrupt 200 only
  task automatic build(input logic m, input int action, output int edges,
                       output int busy_cnt, output int rdnz, output int flags);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    rd_addr = 8'd212;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = -1;
    busy_cnt = 0;
    rdnz = 0;
    flags = busy ? 8 : 0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (action == 1 && n == 101) begin
        start = 1'b1;
        mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      if ((action == 2 || action == 3) && n == 267) begin
        dut.u_ram.mem_q[200] = 8'(model(int'(m), 200)) ^ 8'h5A;
        if (action == 2) dut.u_ram.mem_q[77] = 8'(model(int'(m), 77)) ^ 8'h3C;
      end
      @(posedge clk);
      #1;
      if (n == 1) flags = flags + (done ? 4 : 0) + (error ? 2 : 0) + ((err_addr != 0) ? 1 : 0);
      if (busy) busy_cnt++;
      if (busy && rd_data != 8'd0) rdnz++;
      if (done) begin
        edges = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_build(input string tag, input int edges, input int busy_cnt,
                             input int rdnz, input int flags);
    check({tag, "_done_edges"}, edges, 514);
    check({tag, "_busy_cycles"}, busy_cnt, 512);
    check({tag, "_rd_zero_busy"}, rdnz, 0);
    check({tag, "_edge01_flags"}, flags, 8);
  endtask

  task automatic check_table(input logic m, input int nrand);
    int d, a;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].m == m) begin
        rd(int'(vecs[i].addr), d);
        check($sformatf("vec_m%0d_a%0d", m, vecs[i].addr), d, int'(vecs[i].exp));
      end
    end
    for (int i = 0; i < nrand; i++) begin
      a = int'($urandom_range(0, 255));
      rd(a, d);
      check($sformatf("rand_m%0d_a%0d", m, a), d, model(int'(m), a));
    end
  endtask

  initial begin
    int e, bc, rz, fl, d;
    logic rm;

    vecs[0] = '{1'b0, 8'd0,   8'd32};
    vecs[1] = '{1'b0, 8'd37,  8'd98};
    vecs[2] = '{1'b0, 8'd100, 8'd212};
    vecs[3] = '{1'b0, 8'd124, 8'd255};
    vecs[4] = '{1'b0, 8'd125, 8'd255};
    vecs[5] = '{1'b1, 8'd31,  8'd0};
    vecs[6] = '{1'b1, 8'd32,  8'd0};
    vecs[7] = '{1'b1, 8'd98,  8'd36};
    vecs[8] = '{1'b1, 8'd212, 8'd100};
    vecs[9] = '{1'b1, 8'd255, 8'd123};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_err_addr", int'(err_addr), 0);
    check("rst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(5, d);
    check("rd_before_build", d, 0);

    // C->F build with an ignored start pulse mid-FILL
    build(1'b0, 1, e, bc, rz, fl);
    check_build("c2f", e, bc, rz, fl);
    check("c2f_error", int'(error), 0);
    check("c2f_err_addr", int'(err_addr), 0);
    check_table(1'b0, 20);

    // Rebuild as F->C over a valid C->F table
    build(1'b1, 0, e, bc, rz, fl);
    check_build("rebuild", e, bc, rz, fl);
    check("rebuild_error", int'(error), 0);
    check_table(1'b1, 20);

    // Reset while DONE hides a valid table immediately
    rd(212, d);
    check("done_rd_212", d, 100);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_done_rd_data", int'(rd_data), 0);
    check("rst_done_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(212, d);
    check("after_rst_rd_212", d, 0);

    // Reset at VERIFY cycle 50
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (306) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(i * 60 + 7, d);
      check($sformatf("post_abort_rd_%0d", i * 60 + 7), d, 0);
    end
    repeat (20) @(posedge clk);
    rd(100, d);
    check("post_abort_idle_rd", d, 0);

    rm = 1'($urandom_range(0, 1));
    build(rm, 0, e, bc, rz, fl);
    check_build("rand_mode", e, bc, rz, fl);
    check_table(rm, 30);

    // Corrupt 77 and 200 during VERIFY: first mismatch address kept
    build(1'b0, 2, e, bc, rz, fl);
    check("err1_done_edges", e, 514);
    check("err1_error", int'(error), 1);
    check("err1_err_addr", int'(err_addr), 77);

    // Next build clears the flags at start; only 200 corrupted
    build(1'b1, 3, e, bc, rz, fl);
    check("err2_edge01_flags", fl, 8);
    check("err2_done_edges", e, 514);
    check("err2_error", int'(error), 1);
    check("err2_err_addr", int'(err_addr), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
